// File: rtl/clk_div_ctrl_if.sv
// Handshake and clock-output bundle between the configuration logic and clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int unsigned DIV_W = 8
) ();
  logic             en;
  logic             div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             bclk;
  logic             bclk_rise;
  logic             running;

  modport master (
    output en, div_req, div_val,
    input  div_ack, bclk, bclk_rise, running
  );

  modport slave (
    input  en, div_req, div_val,
    output div_ack, bclk, bclk_rise, running
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable bclk divider: glitch-free start/stop and divisor changes,
// all taking effect only on period boundaries.
module clk_div_ctrl #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 2
) (
  input  logic           mclk,
  input  logic           rst_n,
  clk_div_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_STOPPED  = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             bclk_q, bclk_d;
  logic             rise_q, rise_d;
  logic             ack_q, ack_d;
  logic             running_q, running_d;

  logic             wrap;
  logic             latch;
  logic [DIV_W-1:0] req_div;

  // High phase is ceil(D/2) cycles.
  function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
    return d - (d >> 1);
  endfunction

  assign wrap    = (cnt_q == (div_q - ONE));
  assign latch   = bus.div_req && !pend_q && !ack_q;
  assign req_div = (bus.div_val < TWO) ? TWO : bus.div_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    bclk_d     = 1'b0;
    rise_d     = 1'b0;
    ack_d      = 1'b0;
    running_d  = 1'b0;

    if (latch) begin
      pend_d     = 1'b1;
      pend_div_d = req_div;
    end

    case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = pend_div_q;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
        if (bus.en) begin
          state_d   = ST_RUN;
          bclk_d    = 1'b1;
          rise_d    = 1'b1;
          running_d = 1'b1;
        end
      end

      ST_RUN, ST_STOPPING: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end

        // Stopping only terminates at the wrap, so the last period is never cut short.
        if (bus.en)
          state_d = ST_RUN;
        else if ((state_q == ST_STOPPING) && wrap)
          state_d = ST_STOPPED;
        else
          state_d = ST_STOPPING;

        if (state_d != ST_STOPPED) begin
          running_d = 1'b1;
          bclk_d    = (cnt_d < high_len(div_d));
          rise_d    = (cnt_d == '0);
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_STOPPED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOPPED;
      cnt_q      <= '0;
      div_q      <= DIV_RST_V;
      pend_div_q <= DIV_RST_V;
      pend_q     <= 1'b0;
      bclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      ack_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      bclk_q     <= bclk_d;
      rise_q     <= rise_d;
      ack_q      <= ack_d;
      running_q  <= running_d;
    end
  end

  assign bus.bclk      = bclk_q;
  assign bus.bclk_rise = rise_q;
  assign bus.div_ack   = ack_q;
  assign bus.running   = running_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table plus scripted corner-case sequences.
module tb_clk_div_ctrl;

  localparam int unsigned DW = 8;

  logic mclk = 1'b0;
  logic rst_n;

  always #5 mclk = ~mclk;

  clk_div_ctrl_if #(.DIV_W(DW)) bus ();

  clk_div_ctrl #(
    .DIV_W   (DW),
    .DIV_RST (2)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected output nibble order: {bclk, bclk_rise, running, div_ack}
  typedef struct {
    logic [3:0] exp;
    string      nm;
  } sb_t;

  typedef struct {
    logic       en;
    logic       req;
    logic [7:0] val;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[11];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0] outs();
    return {bus.bclk, bus.bclk_rise, bus.running, bus.div_ack};
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: bclk/rise/run/ack got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic req, input logic [7:0] val,
                     input logic [3:0] exp, input string nm);
    sb_t e;
    bus.en      = en;
    bus.div_req = req;
    bus.div_val = val;
    sb_q.push_back('{exp: exp, nm: nm});
    @(posedge mclk);
    #1;
    e = sb_q.pop_front();
    check(e.nm, outs(), e.exp);
  endtask

  // n cycles of a running period of length d, starting at phase k0
  task automatic run(input int d, input int k0, input int n, input logic en, input string nm);
    int h;
    h = d - d / 2;
    for (int i = 0; i < n; i++) begin
      int k;
      k = (k0 + i) % d;
      cyc(en, 1'b0, 8'd0, {(k < h), (k == 0), 1'b1, 1'b0}, nm);
    end
  endtask

  task automatic set_div(input logic [7:0] v, input string nm);
    cyc(1'b0, 1'b1, v, 4'b0000, {nm, "_latch"});
    cyc(1'b0, 1'b1, v, 4'b0001, {nm, "_ack"});
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, {nm, "_idle"});
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 4'b1110, "d2_start"};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 4'b0010, "d2_low"};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 4'b1110, "d2_rise2"};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 4'b0010, "d2_low2"};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 4'b1110, "d2_stopping_hi"};
    tbl[5]  = '{1'b0, 1'b0, 8'd0, 4'b0010, "d2_stopping_lo"};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, 4'b0000, "d2_stopped"};
    tbl[7]  = '{1'b0, 1'b1, 8'd5, 4'b0000, "d5_latch"};
    tbl[8]  = '{1'b0, 1'b1, 8'd5, 4'b0001, "d5_ack"};
    tbl[9]  = '{1'b0, 1'b1, 8'd5, 4'b0000, "req_during_ack"};
    tbl[10] = '{1'b0, 1'b0, 8'd0, 4'b0000, "no_second_ack"};

    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.div_req = 1'b0;
    bus.div_val = '0;
    repeat (2) @(posedge mclk);
    #1;
    check("reset_state", outs(), 4'b0000);
    rst_n = 1'b1;

    foreach (tbl[i]) cyc(tbl[i].en, tbl[i].req, tbl[i].val, tbl[i].exp, tbl[i].nm);

    // odd divisor: 1,1,1,0,0
    run(5, 0, 10, 1'b1, "d5_run");
    run(5, 0, 5, 1'b0, "d5_stopping");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "d5_stopped");

    // glitch-free change 4 -> 10 requested at cnt=1
    set_div(8'd4, "d4");
    run(4, 0, 2, 1'b1, "d4_run");
    cyc(1'b1, 1'b1, 8'd10, 4'b0010, "chg_latch");
    cyc(1'b1, 1'b1, 8'd10, 4'b0010, "chg_hold");
    cyc(1'b1, 1'b1, 8'd10, 4'b1111, "chg_ack_rise");
    run(10, 1, 19, 1'b1, "d10_run");
    run(10, 0, 10, 1'b0, "d10_stopping");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "d10_stopped");

    // clean stop at D=6, en dropped at cnt=2
    set_div(8'd6, "d6");
    run(6, 0, 3, 1'b1, "d6_run");
    run(6, 3, 3, 1'b0, "d6_tail");
    repeat (3) cyc(1'b0, 1'b0, 8'd0, 4'b0000, "d6_stopped");

    // clamp, then stop with a pending change
    set_div(8'd0, "clamp");
    run(2, 0, 4, 1'b1, "clamp_run");
    cyc(1'b0, 1'b1, 8'd3, 4'b1110, "pend_latch");
    cyc(1'b0, 1'b1, 8'd3, 4'b0010, "pend_hold");
    cyc(1'b0, 1'b1, 8'd3, 4'b0001, "stop_with_ack");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "stop_idle");
    run(3, 0, 6, 1'b1, "d3_run");
    run(3, 0, 3, 1'b0, "d3_stopping");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "d3_stopped");

    // start and latch on the same edge: old D first, new D at first wrap
    cyc(1'b1, 1'b1, 8'd4, 4'b1110, "sim_start");
    cyc(1'b1, 1'b1, 8'd4, 4'b1010, "sim_cnt1");
    cyc(1'b1, 1'b1, 8'd4, 4'b0010, "sim_cnt2");
    cyc(1'b1, 1'b1, 8'd4, 4'b1111, "sim_apply");
    run(4, 1, 3, 1'b1, "d4b_run");
    run(4, 0, 4, 1'b0, "d4b_stopping");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "d4b_stopped");

    // reset mid-period at D=8, cnt=1, with a change pending
    set_div(8'd8, "d8");
    run(8, 0, 1, 1'b1, "d8_run");
    cyc(1'b1, 1'b1, 8'd3, 4'b1010, "d8_pend");
    bus.en      = 1'b0;
    bus.div_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), 4'b0000);
    @(posedge mclk);
    #1;
    check("rst_hold", outs(), 4'b0000);
    rst_n = 1'b1;
    run(2, 0, 4, 1'b1, "post_rst_d2");
    run(2, 0, 2, 1'b0, "post_rst_stopping");
    cyc(1'b0, 1'b0, 8'd0, 4'b0000, "post_rst_stopped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
